// File: rtl/sram1r1w_port_ctrl.sv
// Read/write front end for a two-port byte-write SRAM macro (port A read, port B write).
// Converts valid/ready requests into active-low strobes and resolves same-address collisions.
module sram1r1w_port_ctrl #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 64,
    parameter int ADDRW = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ReadEn,
    output logic                 ReadReady,
    input  logic [ADDRW-1:0]     ReadAddr,
    input  logic                 ReadStall,
    output logic                 ReadValid,
    output logic [WIDTH-1:0]     ReadData,
    input  logic                 WriteEn,
    input  logic [ADDRW-1:0]     WriteAddr,
    input  logic [WIDTH-1:0]     WriteData,
    input  logic [WIDTH/8-1:0]   WriteByteMask,
    output logic                 CEBA,
    output logic                 WEBA,
    output logic [ADDRW-1:0]     AA,
    output logic [WIDTH-1:0]     DA,
    output logic [WIDTH-1:0]     BWEBA,
    input  logic [WIDTH-1:0]     QA,
    output logic                 CEBB,
    output logic                 WEBB,
    output logic [ADDRW-1:0]     AB,
    output logic [WIDTH-1:0]     DB,
    output logic [WIDTH-1:0]     BWEBB,
    input  logic [WIDTH-1:0]     QB
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LIVE  = 2'd1,
        ST_HELD  = 2'd2
    } rd_state_e;

    rd_state_e          state_q, state_d;
    logic               fwd_q, fwd_d;
    logic [WIDTH-1:0]   fwd_data_q, fwd_data_d;
    logic [WIDTH-1:0]   hold_q, hold_d;

    logic               wr_act_s;
    logic               coll_s;
    logic               full_mask_s;
    logic               partial_s;
    logic               rd_ready_s;
    logic               rd_acc_s;
    logic [WIDTH-1:0]   live_data_s;
    logic               unused_s;

    // QB is never read; the depth check keeps DEPTH tied to ADDRW.
    assign unused_s = ^{QB, (DEPTH == (1 << ADDRW))};

    // Request decode, collision detection and macro strobe generation.
    always_comb begin
        wr_act_s    = WriteEn & (|WriteByteMask) & ~reset;
        full_mask_s = &WriteByteMask;
        coll_s      = wr_act_s & ReadEn & (ReadAddr == WriteAddr);
        partial_s   = coll_s & ~full_mask_s;
        rd_ready_s  = ~reset & ~(ReadValid & ReadStall) & ~partial_s;
        rd_acc_s    = ReadEn & rd_ready_s;

        ReadReady = rd_ready_s;
        CEBA      = ~rd_acc_s;
        WEBA      = 1'b1;
        AA        = ReadAddr;
        DA        = '0;
        BWEBA     = '1;

        CEBB = ~wr_act_s;
        WEBB = ~wr_act_s;
        AB   = WriteAddr;
        DB   = WriteData;
        for (int i = 0; i < WIDTH; i++) begin
            BWEBB[i] = ~WriteByteMask[i/8];
        end
    end

    // Read-side state machine, forwarding capture and hold-register load.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        // Macro output is undefined on a full-word collision, so the write data stands in.
        live_data_s = fwd_q ? fwd_data_q : QA;
        fwd_d       = rd_acc_s & coll_s & full_mask_s;
        if (rd_acc_s && coll_s && full_mask_s) begin
            fwd_data_d = WriteData;
        end else begin
            fwd_data_d = fwd_data_q;
        end

        case (state_q)
            ST_EMPTY: begin
                if (rd_acc_s) begin
                    state_d = ST_LIVE;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_LIVE: begin
                if (ReadStall) begin
                    state_d = ST_HELD;
                    hold_d  = live_data_s;
                end else if (rd_acc_s) begin
                    state_d = ST_LIVE;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_HELD: begin
                if (ReadStall) begin
                    state_d = ST_HELD;
                end else if (rd_acc_s) begin
                    state_d = ST_LIVE;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        case (state_q)
            ST_LIVE: begin
                ReadValid = 1'b1;
                ReadData  = live_data_s;
            end
            ST_HELD: begin
                ReadValid = 1'b1;
                ReadData  = hold_q;
            end
            default: begin
                ReadValid = 1'b0;
                ReadData  = '0;
            end
        endcase
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            fwd_q      <= fwd_d;
            fwd_data_q <= fwd_data_d;
            hold_q     <= hold_d;
        end
    end

endmodule

// File: tb/tb_sram1r1w_port_ctrl.sv
// Directed bench for sram1r1w_port_ctrl with a behavioural two-port byte-write SRAM model.
module tb_sram1r1w_port_ctrl;

    localparam int DEPTH = 512;
    localparam int WIDTH = 64;
    localparam int ADDRW = 9;

    logic               clk = 1'b0;
    logic               reset;
    logic               ReadEn;
    logic               ReadReady;
    logic [ADDRW-1:0]   ReadAddr;
    logic               ReadStall;
    logic               ReadValid;
    logic [WIDTH-1:0]   ReadData;
    logic               WriteEn;
    logic [ADDRW-1:0]   WriteAddr;
    logic [WIDTH-1:0]   WriteData;
    logic [7:0]         WriteByteMask;
    logic               CEBA, WEBA, CEBB, WEBB;
    logic [ADDRW-1:0]   AA, AB;
    logic [WIDTH-1:0]   DA, BWEBA, QA, DB, BWEBB, QB;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [WIDTH-1:0] GARBAGE = 64'hBAD0_BAD0_BAD0_BAD0;

    always #5 clk = ~clk;

    sram1r1w_port_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDRW(ADDRW)) dut (
        .clk(clk), .reset(reset),
        .ReadEn(ReadEn), .ReadReady(ReadReady), .ReadAddr(ReadAddr),
        .ReadStall(ReadStall), .ReadValid(ReadValid), .ReadData(ReadData),
        .WriteEn(WriteEn), .WriteAddr(WriteAddr), .WriteData(WriteData),
        .WriteByteMask(WriteByteMask),
        .CEBA(CEBA), .WEBA(WEBA), .AA(AA), .DA(DA), .BWEBA(BWEBA), .QA(QA),
        .CEBB(CEBB), .WEBB(WEBB), .AB(AB), .DB(DB), .BWEBB(BWEBB), .QB(QB)
    );

    // Behavioural SRAM: read data undefined (garbage) on same-address collision.
    logic [WIDTH-1:0] mem [0:DEPTH-1];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        QA = '0;
        QB = '0;
    end
    always @(posedge clk) begin
        logic [WIDTH-1:0] w;
        if (!CEBA) QA <= (!CEBB && !WEBB && AB == AA) ? GARBAGE : mem[AA];
        if (!CEBB && !WEBB) begin
            w = mem[AB];
            for (int b = 0; b < WIDTH; b++) if (!BWEBB[b]) w[b] = DB[b];
            mem[AB] <= w;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ReadEn = 1'b0; ReadAddr = '0; ReadStall = 1'b0;
        WriteEn = 1'b0; WriteAddr = '0; WriteData = '0; WriteByteMask = 8'h00;
    endtask

    task automatic do_write(input logic [ADDRW-1:0] a, input logic [WIDTH-1:0] d, input logic [7:0] m);
        WriteEn = 1'b1; WriteAddr = a; WriteData = d; WriteByteMask = m;
        step();
        WriteEn = 1'b0; WriteByteMask = 8'h00;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle();
        ReadEn = 1'b1; ReadAddr = 9'h005;
        WriteEn = 1'b1; WriteAddr = 9'h005; WriteData = 64'hFFFF_FFFF_FFFF_FFFF; WriteByteMask = 8'hFF;
        #1;
        n_cmp++; if (ReadReady !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b exp 0", ReadReady); end
        n_cmp++; if ({CEBA, WEBA, CEBB, WEBB} !== 4'b1111) begin n_err++; $display("FAIL rst_strobes: got %b exp 1111", {CEBA, WEBA, CEBB, WEBB}); end
        step(); step();
        idle(); reset = 1'b0;
        #1;
        n_cmp++; if (ReadValid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b exp 0", ReadValid); end
        n_cmp++; if (ReadData !== 64'h0) begin n_err++; $display("FAIL rst_data: got %h exp 0", ReadData); end
        n_cmp++; if (BWEBA !== 64'hFFFF_FFFF_FFFF_FFFF || DA !== 64'h0) begin n_err++; $display("FAIL port_a_ties: got %h/%h exp all-ones/0", BWEBA, DA); end
        n_cmp++; if (mem[5] !== 64'h0) begin n_err++; $display("FAIL rst_no_write: got %h exp 0", mem[5]); end
    endtask

    task automatic test_write_read();
        do_write(9'h000, 64'h1234_5678_9ABC_DEF0, 8'hFF);
        ReadEn = 1'b1; ReadAddr = 9'h000;
        #1;
        n_cmp++; if (ReadReady !== 1'b1 || CEBA !== 1'b0) begin n_err++; $display("FAIL wr_rd_accept: got rdy=%b ceba=%b exp 1/0", ReadReady, CEBA); end
        step();
        ReadEn = 1'b0;
        n_cmp++; if (ReadValid !== 1'b1) begin n_err++; $display("FAIL wr_rd_valid: got %b exp 1", ReadValid); end
        n_cmp++; if (ReadData !== 64'h1234_5678_9ABC_DEF0) begin n_err++; $display("FAIL wr_rd_data: got %h exp 123456789abcdef0", ReadData); end
        step();
        n_cmp++; if (ReadValid !== 1'b0) begin n_err++; $display("FAIL wr_rd_empty: got %b exp 0", ReadValid); end
    endtask

    task automatic test_full_collision();
        do_write(9'h1FF, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
        ReadEn = 1'b1; ReadAddr = 9'h1FF;
        WriteEn = 1'b1; WriteAddr = 9'h1FF; WriteData = 64'h5555_5555_5555_5555; WriteByteMask = 8'hFF;
        #1;
        n_cmp++; if (ReadReady !== 1'b1) begin n_err++; $display("FAIL fcoll_ready: got %b exp 1", ReadReady); end
        step();
        idle();
        n_cmp++; if (ReadData !== 64'h5555_5555_5555_5555 || ReadValid !== 1'b1) begin n_err++; $display("FAIL fcoll_fwd: got %h v=%b exp 5555555555555555 v=1", ReadData, ReadValid); end
        step();
    endtask

    task automatic test_partial_collision();
        do_write(9'h010, 64'h1111_1111_1111_1111, 8'hFF);
        ReadEn = 1'b1; ReadAddr = 9'h010;
        WriteEn = 1'b1; WriteAddr = 9'h010; WriteData = 64'hFF00_0000_0000_0000; WriteByteMask = 8'h80;
        #1;
        n_cmp++; if (ReadReady !== 1'b0 || CEBA !== 1'b1) begin n_err++; $display("FAIL pcoll_block: got rdy=%b ceba=%b exp 0/1", ReadReady, CEBA); end
        n_cmp++; if (CEBB !== 1'b0 || BWEBB !== 64'h00FF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL pcoll_write: got cebb=%b bweb=%h exp 0/00ffffffffffffff", CEBB, BWEBB); end
        step();
        WriteEn = 1'b0; WriteByteMask = 8'h00;
        #1;
        n_cmp++; if (ReadValid !== 1'b0 || ReadReady !== 1'b1) begin n_err++; $display("FAIL pcoll_retry: got v=%b rdy=%b exp 0/1", ReadValid, ReadReady); end
        step();
        idle();
        n_cmp++; if (ReadData !== 64'hFF11_1111_1111_1111 || ReadValid !== 1'b1) begin n_err++; $display("FAIL pcoll_data: got %h v=%b exp ff11111111111111 v=1", ReadData, ReadValid); end
        step();
    endtask

    task automatic test_stall_hold();
        do_write(9'h020, 64'h0000_0000_00C0_FFEE, 8'hFF);
        do_write(9'h021, 64'h0000_0000_0000_0021, 8'hFF);
        ReadEn = 1'b1; ReadAddr = 9'h020;
        step();
        ReadAddr = 9'h021; ReadStall = 1'b1;
        WriteEn = 1'b1; WriteAddr = 9'h020; WriteData = 64'h0; WriteByteMask = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (ReadData !== 64'h00C0_FFEE || ReadValid !== 1'b1) begin n_err++; $display("FAIL stall_data[%0d]: got %h v=%b exp c0ffee v=1", c, ReadData, ReadValid); end
            n_cmp++; if (ReadReady !== 1'b0 || CEBA !== 1'b1) begin n_err++; $display("FAIL stall_ready[%0d]: got rdy=%b ceba=%b exp 0/1", c, ReadReady, CEBA); end
            step();
        end
        ReadStall = 1'b0; WriteEn = 1'b0; WriteByteMask = 8'h00;
        #1;
        n_cmp++; if (ReadReady !== 1'b1 || CEBA !== 1'b0 || ReadData !== 64'h00C0_FFEE) begin n_err++; $display("FAIL stall_release: got rdy=%b ceba=%b d=%h exp 1/0/c0ffee", ReadReady, CEBA, ReadData); end
        step();
        idle();
        n_cmp++; if (ReadData !== 64'h21 || ReadValid !== 1'b1) begin n_err++; $display("FAIL stall_next: got %h v=%b exp 21 v=1", ReadData, ReadValid); end
        n_cmp++; if (mem[9'h020] !== 64'h0) begin n_err++; $display("FAIL stall_write: got %h exp 0", mem[9'h020]); end
        step();
    endtask

    task automatic test_zero_mask();
        do_write(9'h030, 64'h3333_3333_3333_3333, 8'hFF);
        ReadEn = 1'b1; ReadAddr = 9'h030;
        WriteEn = 1'b1; WriteAddr = 9'h030; WriteData = 64'hFFFF_FFFF_FFFF_FFFF; WriteByteMask = 8'h00;
        #1;
        n_cmp++; if (CEBB !== 1'b1 || ReadReady !== 1'b1) begin n_err++; $display("FAIL zmask_strobe: got cebb=%b rdy=%b exp 1/1", CEBB, ReadReady); end
        step();
        idle();
        n_cmp++; if (ReadData !== 64'h3333_3333_3333_3333) begin n_err++; $display("FAIL zmask_data: got %h exp 3333333333333333", ReadData); end
        step();
    endtask

    task automatic test_reset_mid_stall();
        do_write(9'h1F5, 64'hDEAD_BEEF_0000_01F5, 8'hFF);
        ReadEn = 1'b1; ReadAddr = 9'h1F5;
        step();
        ReadEn = 1'b0; ReadStall = 1'b1;
        step(); step();
        reset = 1'b1;
        WriteEn = 1'b1; WriteAddr = 9'h100; WriteData = 64'h1; WriteByteMask = 8'hFF;
        ReadEn = 1'b1; ReadAddr = 9'h1F5;
        #1;
        n_cmp++; if (CEBA !== 1'b1 || CEBB !== 1'b1 || ReadReady !== 1'b0) begin n_err++; $display("FAIL mrst_strobes: got ceba=%b cebb=%b rdy=%b exp 1/1/0", CEBA, CEBB, ReadReady); end
        step();
        reset = 1'b0; ReadStall = 1'b0; WriteEn = 1'b0; WriteByteMask = 8'h00; ReadEn = 1'b0;
        n_cmp++; if (ReadValid !== 1'b0 || ReadData !== 64'h0) begin n_err++; $display("FAIL mrst_cleared: got v=%b d=%h exp 0/0", ReadValid, ReadData); end
        ReadEn = 1'b1;
        step();
        ReadEn = 1'b0;
        n_cmp++; if (ReadValid !== 1'b1 || ReadData !== 64'hDEAD_BEEF_0000_01F5) begin n_err++; $display("FAIL mrst_read: got v=%b d=%h exp 1/deadbeef000001f5", ReadValid, ReadData); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [ADDRW-1:0] addrs [3];
        logic [WIDTH-1:0] exps  [3];
        addrs[0] = 9'h000; exps[0] = 64'h1234_5678_9ABC_DEF0;
        addrs[1] = 9'h1FF; exps[1] = 64'h5555_5555_5555_5555;
        addrs[2] = 9'h010; exps[2] = 64'hFF11_1111_1111_1111;
        ReadEn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ReadAddr = addrs[k];
            step();
            n_cmp++; if (ReadValid !== 1'b1 || ReadData !== exps[k]) begin n_err++; $display("FAIL b2b[%0d]: got v=%b d=%h exp 1/%h", k, ReadValid, ReadData, exps[k]); end
        end
        idle();
        step();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #1;
        test_reset();
        test_write_read();
        test_full_collision();
        test_partial_collision();
        test_stall_hold();
        test_zero_mask();
        test_reset_mid_stall();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
